// File: rtl/decode_ctrl_queue.sv
// Front-end decode stage: decodes opcode/funct3 into a control bundle, tags it
// with the ROB tag and buffers it in a DEPTH-entry valid/ready FIFO with flush.
module decode_ctrl_queue #(
  parameter int TAG_W         = 6,
  parameter int DEPTH         = 4,
  parameter bit ENABLE_BRANCH = 1'b1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_mem_read,
  output logic             out_mem_to_reg,
  output logic             out_mem_write,
  output logic             out_alu_src,
  output logic             out_reg_write,
  output logic             out_load_upper,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_illegal,
  output logic [1:0]       out_alu_op,
  output logic [1:0]       out_mem_size,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             mem_read;
    logic             mem_to_reg;
    logic             mem_write;
    logic             alu_src;
    logic             reg_write;
    logic             load_upper;
    logic             branch;
    logic             jump;
    logic             illegal;
    logic [1:0]       alu_op;
    logic [1:0]       mem_size;
  } entry_t;

  entry_t           dec;
  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;
  logic             unused_funct3;

  assign unused_funct3 = in_funct3[2];

  always_comb begin
    dec     = '0;
    dec.tag = in_tag;
    unique case (in_opcode)
      OP_R: begin
        dec.alu_op    = 2'b10;
        dec.reg_write = 1'b1;
      end
      OP_I: begin
        dec.alu_op    = 2'b11;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_STORE: begin
        if (in_funct3[1:0] == 2'b11) begin
          dec.illegal = 1'b1;
        end else begin
          dec.mem_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.mem_size  = in_funct3[1:0];
        end
      end
      OP_LOAD: begin
        if (in_funct3[1:0] == 2'b11) begin
          dec.illegal = 1'b1;
        end else begin
          dec.mem_read   = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.alu_src    = 1'b1;
          dec.reg_write  = 1'b1;
          dec.mem_size   = in_funct3[1:0];
        end
      end
      OP_LUI: begin
        dec.alu_op     = 2'b01;
        dec.load_upper = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OP_BRANCH: begin
        if (ENABLE_BRANCH) begin
          dec.branch = 1'b1;
          dec.alu_op = 2'b01;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_JAL: begin
        if (ENABLE_BRANCH) begin
          dec.jump      = 1'b1;
          dec.reg_write = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // in_ready depends only on occupancy and flush, never on out_ready.
  assign in_ready  = (count != FULL_CNT) && !flush;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_count <= '0;
    end else if (push && dec.illegal && (illegal_count != '1)) begin
      illegal_count <= illegal_count + 1'b1;
    end
  end

  // Storage is unreset; masking with out_valid keeps outputs clean.
  assign head = out_valid ? mem[rd_ptr] : '0;

  assign out_tag        = head.tag;
  assign out_mem_read   = head.mem_read;
  assign out_mem_to_reg = head.mem_to_reg;
  assign out_mem_write  = head.mem_write;
  assign out_alu_src    = head.alu_src;
  assign out_reg_write  = head.reg_write;
  assign out_load_upper = head.load_upper;
  assign out_branch     = head.branch;
  assign out_jump       = head.jump;
  assign out_illegal    = head.illegal;
  assign out_alu_op     = head.alu_op;
  assign out_mem_size   = head.mem_size;

endmodule

// File: tb/tb_decode_ctrl_queue.sv
// Bench for decode_ctrl_queue: directed steps then random traffic, checked
// against a queue-based reference model for two parameterisations.
module tb_decode_ctrl_queue;

  localparam int TAG_W = 6;
  localparam int DEPTH = 4;
  localparam int CNT_A = 8;
  localparam int CNT_B = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [6:0]       in_opcode;
  logic [2:0]       in_funct3;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  logic             a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [TAG_W-1:0] a_tag, b_tag;
  logic             a_mr, a_mtr, a_mw, a_as, a_rw, a_lu, a_br, a_j, a_il;
  logic             b_mr, b_mtr, b_mw, b_as, b_rw, b_lu, b_br, b_j, b_il;
  logic [1:0]       a_aop, a_ms, b_aop, b_ms;
  logic [CNT_A-1:0] a_cnt;
  logic [CNT_B-1:0] b_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: queued expected bundles {tag, 13 control bits} and counters.
  logic [18:0] qa[$];
  logic [18:0] qb[$];
  int          cnt_a, cnt_b;

  always #5 clk = ~clk;

  decode_ctrl_queue #(.TAG_W(TAG_W), .DEPTH(DEPTH), .ENABLE_BRANCH(1'b1), .CNT_W(CNT_A)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_tag(a_tag),
    .out_mem_read(a_mr), .out_mem_to_reg(a_mtr), .out_mem_write(a_mw), .out_alu_src(a_as),
    .out_reg_write(a_rw), .out_load_upper(a_lu), .out_branch(a_br), .out_jump(a_j),
    .out_illegal(a_il), .out_alu_op(a_aop), .out_mem_size(a_ms), .illegal_count(a_cnt));

  decode_ctrl_queue #(.TAG_W(TAG_W), .DEPTH(DEPTH), .ENABLE_BRANCH(1'b0), .CNT_W(CNT_B)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_tag(b_tag),
    .out_mem_read(b_mr), .out_mem_to_reg(b_mtr), .out_mem_write(b_mw), .out_alu_src(b_as),
    .out_reg_write(b_rw), .out_load_upper(b_lu), .out_branch(b_br), .out_jump(b_j),
    .out_illegal(b_il), .out_alu_op(b_aop), .out_mem_size(b_ms), .illegal_count(b_cnt));

  // Control bits: {mem_read, mem_to_reg, mem_write, alu_src, reg_write,
  //                load_upper, branch, jump, illegal, alu_op[1:0], mem_size[1:0]}
  function automatic logic [12:0] ref_ctrl(logic [6:0] op, logic [2:0] f3, bit eb);
    bit mr = 0, mtr = 0, mw = 0, as = 0, rw = 0, lu = 0, br = 0, j = 0, il = 0;
    logic [1:0] aop = 2'b00, ms = 2'b00;
    case (op)
      7'b0110011: begin aop = 2'b10; rw = 1; end
      7'b0010011: begin aop = 2'b11; as = 1; rw = 1; end
      7'b0100011: if (f3[1:0] == 2'b11) il = 1; else begin mw = 1; as = 1; ms = f3[1:0]; end
      7'b0000011: if (f3[1:0] == 2'b11) il = 1;
                  else begin mr = 1; mtr = 1; as = 1; rw = 1; ms = f3[1:0]; end
      7'b0110111: begin aop = 2'b01; lu = 1; rw = 1; end
      7'b1100011: if (eb) begin br = 1; aop = 2'b01; end else il = 1;
      7'b1101111: if (eb) begin j = 1; rw = 1; end else il = 1;
      default:    il = 1;
    endcase
    return {mr, mtr, mw, as, rw, lu, br, j, il, aop, ms};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(string where);
    logic [18:0] ha, hb;
    ha = (qa.size() > 0) ? qa[0] : 19'd0;
    hb = (qb.size() > 0) ? qb[0] : 19'd0;
    chk({where, ":a.in_ready"}, 32'(a_in_ready), 32'((qa.size() < DEPTH) && !flush));
    chk({where, ":a.out_valid"}, 32'(a_out_valid), 32'(qa.size() > 0));
    chk({where, ":a.bundle"}, 32'({a_tag, a_mr, a_mtr, a_mw, a_as, a_rw, a_lu, a_br, a_j, a_il, a_aop, a_ms}), 32'(ha));
    chk({where, ":a.illegal_count"}, 32'(a_cnt), 32'(cnt_a));
    chk({where, ":b.in_ready"}, 32'(b_in_ready), 32'((qb.size() < DEPTH) && !flush));
    chk({where, ":b.out_valid"}, 32'(b_out_valid), 32'(qb.size() > 0));
    chk({where, ":b.bundle"}, 32'({b_tag, b_mr, b_mtr, b_mw, b_as, b_rw, b_lu, b_br, b_j, b_il, b_aop, b_ms}), 32'(hb));
    chk({where, ":b.illegal_count"}, 32'(b_cnt), 32'(cnt_b));
  endtask

  // Applies the clock-edge rules to one model queue.
  task automatic model_edge(inout logic [18:0] q[$], inout int cnt, input bit eb, input int cmax);
    logic [12:0] c;
    bit do_push, do_pop;
    if (flush) begin
      q.delete();
      return;
    end
    do_push = in_valid && (q.size() < DEPTH);
    do_pop  = out_ready && (q.size() > 0);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      c = ref_ctrl(in_opcode, in_funct3, eb);
      q.push_back({in_tag, c});
      if (c[4] && cnt < cmax) cnt++;
    end
  endtask

  task automatic step(string where, bit v, logic [6:0] op, logic [2:0] f3,
                      logic [TAG_W-1:0] tg, bit rdy, bit fl);
    in_valid = v; in_opcode = op; in_funct3 = f3; in_tag = tg;
    out_ready = rdy; flush = fl;
    #3;
    check_outputs(where);
    @(posedge clk);
    model_edge(qa, cnt_a, 1'b1, (1 << CNT_A) - 1);
    model_edge(qb, cnt_b, 1'b0, (1 << CNT_B) - 1);
    #1;
  endtask

  logic [6:0] ops[8] = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011,
                         7'b0110111, 7'b1100011, 7'b1101111, 7'b1111111};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_opcode = '0; in_funct3 = '0;
    in_tag = '0; out_ready = 1'b0;
    cnt_a = 0; cnt_b = 0;
    #12;
    check_outputs("in_reset");
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Single R-type, observed one cycle later and popped.
    step("r_push", 1, 7'b0110011, 3'b000, 6'd5, 1, 0);
    step("r_head", 0, 7'b0, 3'b000, 6'd0, 1, 0);
    step("r_gone", 0, 7'b0, 3'b000, 6'd0, 1, 0);

    // LUI then I-type; second head must not keep load_upper.
    step("lui_push", 1, 7'b0110111, 3'b000, 6'd10, 0, 0);
    step("i_push", 1, 7'b0010011, 3'b000, 6'd11, 0, 0);
    step("lui_head", 0, 7'b0, 3'b000, 6'd0, 1, 0);
    step("i_head", 0, 7'b0, 3'b000, 6'd0, 1, 0);
    step("lui_i_empty", 0, 7'b0, 3'b000, 6'd0, 1, 0);

    // Fill with word loads, hold while full, then drain with input pending.
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 7'b0000011, 3'b010, 6'(20 + i), 0, 0);
    step("full_hold", 1, 7'b0000011, 3'b010, 6'd30, 0, 0);
    step("full_pop", 1, 7'b0000011, 3'b010, 6'd31, 1, 0);
    for (int i = 0; i < DEPTH + 2; i++) step("drain", 0, 7'b0, 3'b000, 6'd0, 1, 0);

    // Illegal opcode, illegal store size, branch (illegal only without branch support).
    step("ill_op", 1, 7'b1111111, 3'b000, 6'd40, 0, 0);
    step("ill_st", 1, 7'b0100011, 3'b011, 6'd41, 0, 0);
    step("br_push", 1, 7'b1100011, 3'b000, 6'd42, 0, 0);
    step("jal_push", 1, 7'b1101111, 3'b000, 6'd43, 0, 0);
    for (int i = 0; i < 5; i++) step("ill_drain", 0, 7'b0, 3'b000, 6'd0, 1, 0);

    // Flush with push and pop presented in the same cycle.
    for (int i = 0; i < 3; i++) step("pre_flush", 1, 7'b0000011, 3'b000, 6'(50 + i), 0, 0);
    step("flush", 1, 7'b1111111, 3'b000, 6'd60, 1, 1);
    step("post_flush", 0, 7'b0, 3'b000, 6'd0, 1, 0);

    // Asynchronous reset mid-cycle with two entries queued.
    step("pre_rst0", 1, 7'b1111111, 3'b000, 6'd61, 0, 0);
    step("pre_rst1", 1, 7'b0100011, 3'b001, 6'd62, 0, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0;
    chk("async_rst:a.out_valid", 32'(a_out_valid), 32'd0);
    chk("async_rst:b.out_valid", 32'(b_out_valid), 32'd0);
    #3 rst = 1'b0;
    #1;
    check_outputs("post_rst");
    @(posedge clk); #1;

    // Random traffic, including occasional flushes and many illegal opcodes.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 7)],
           3'($urandom), 6'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0));
    end
    step("final", 0, 7'b0, 3'b000, 6'd0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_queue.md
Name: decode_ctrl_queue

Overview:
Registered, parametrised successor to the combinational main-control decoder. It decodes opcode/funct3 into the full control bundle, tags each entry with its ROB tag, and buffers decoded entries in a DEPTH-entry FIFO. The FIFO has valid/ready handshakes on both sides and a synchronous flush. It sits between fetch and rename/dispatch in the out-of-order front end.

Parameters:
TAG_W, 6, width of ROB tag carried with each instruction
DEPTH, 4, FIFO entries (power of two, >=2)
ENABLE_BRANCH, 1, 1 = decode BRANCH/JAL opcodes; 0 = treat them as illegal
CNT_W, 8, width of saturating illegal-opcode counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous pipeline flush (mispredict/exception)
in_valid  input  1  upstream instruction valid
in_ready  output  1  queue can accept this cycle
in_opcode  input  7  instr[6:0]
in_funct3  input  3  instr[14:12]
in_tag  input  TAG_W  ROB tag
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head
out_tag  output  TAG_W  tag of head
out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write, out_load_upper, out_branch, out_jump, out_illegal  output  1 each  decoded controls of head
out_alu_op  output  2  ALU op class
out_mem_size  output  2  00 byte, 01 half, 10 word
illegal_count  output  CNT_W  saturating count of accepted illegal opcodes

Behaviour:
- Decode (combinational, at input, stored in FIFO). Every field defaults to 0, including load_upper.
  - R 0110011: alu_op=10, reg_write.
  - I 0010011: alu_op=11, alu_src, reg_write.
  - S 0100011: mem_write, alu_src, mem_size=funct3[1:0].
  - LOAD 0000011: mem_read, mem_to_reg, alu_src, reg_write, mem_size=funct3[1:0].
  - LUI 0110111: alu_op=01, load_upper, reg_write.
  - BRANCH 1100011 (ENABLE_BRANCH=1): branch, alu_op=01.
  - JAL 1101111 (ENABLE_BRANCH=1): jump, reg_write.
  - Any other opcode: illegal=1, all other fields 0.
- mem_size is 00 for every non-memory opcode. funct3[1:0]=11 on load/store is illegal: illegal=1, all other fields 0.
- FIFO: wr_ptr, rd_ptr (log2(DEPTH) bits, wrap modulo DEPTH) and count (log2(DEPTH)+1 bits).
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count < DEPTH) && !flush. in_ready has no combinational dependence on out_ready.
- out_valid = (count != 0). Outputs are driven from the head entry register. All out_* fields are 0 when out_valid=0.
- Latency: an entry pushed at edge N is visible on out_* after edge N (min 1 cycle, fall-through not permitted).
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- When full: in_ready=0 even if out_ready=1 in the same cycle.
- Pop from empty and push when not ready are ignored; no state change.
- flush (synchronous, highest priority): at the edge, count=0, wr_ptr=rd_ptr=0. A push or pop presented in the flush cycle has no effect. out_valid=0 the cycle after. illegal_count is not affected by flush.
- illegal_count increments on each accepted push with illegal=1. It saturates at all-ones.
- Reset (async): count, pointers and illegal_count go to 0, out_valid=0, all out_* fields 0, in_ready=1 after rst deasserts. Reset mid-stream discards all entries.
- No X on outputs after reset. Storage contents need no reset, but outputs are masked by out_valid.

Test Plan:
- Reset then one R-type push (opcode 0110011, tag 5), out_ready=1 -> one cycle later out_valid=1, tag=5, alu_op=10, reg_write=1, all others 0; popped, out_valid=0 next cycle.
- LUI then I-type back-to-back -> head1 load_upper=1, alu_op=01; head2 load_upper=0 (no stale latch), alu_op=11, alu_src=1.
- out_ready=0, push DEPTH=4 loads with funct3=010 -> in_ready drops after 4th push, count=4, mem_size=10, mem_read=mem_to_reg=1. Then out_ready=1 with in_valid=1 -> in_ready stays 0 while full, FIFO drains in order with tags preserved.
- Push opcode 1111111, then store with funct3=011 -> both emerge with illegal=1, other fields 0; illegal_count=2. With ENABLE_BRANCH=0, opcode 1100011 -> illegal=1.
- Three entries queued, flush asserted with in_valid=1 and out_ready=1 -> next cycle out_valid=0, count=0, the presented input is not enqueued, illegal_count unchanged.
- Assert rst asynchronously mid-cycle with 2 entries queued -> out_valid falls immediately without a clock edge; after release in_ready=1 and illegal_count=0.
